// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream handshakes plus the external simple dual-port RAM bus.
// slave is the controller side, master is the user/RAM side.
interface ram_fifo_ctrl_if #(
    parameter int Width = 18,
    parameter int Depth = 64
);
    localparam int AddrBits = $clog2(Depth);
    localparam int CntBits  = $clog2(Depth + 3);

    logic                in_valid;
    logic                in_ready;
    logic [Width-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [Width-1:0]    out_data;
    logic [CntBits-1:0]  count;
    logic                ram_wr_en;
    logic [AddrBits-1:0] ram_wr_addr;
    logic [Width-1:0]    ram_wr_data;
    logic [AddrBits-1:0] ram_rd_addr;
    logic [Width-1:0]    ram_rd_data;

    modport slave (
        input  in_valid, in_data, out_ready, ram_rd_data,
        output in_ready, out_valid, out_data, count,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    modport master (
        output in_valid, in_data, out_ready, ram_rd_data,
        input  in_ready, out_valid, out_data, count,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external 1-cycle-latency simple dual-port RAM,
// with a 2-entry show-ahead output buffer hiding the read latency.
module ram_fifo_ctrl #(
    parameter int Width = 18,
    parameter int Depth = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_fifo_ctrl_if.slave bus
);
    localparam int AddrBits = $clog2(Depth);
    localparam int CntBits  = $clog2(Depth + 3);
    localparam logic [AddrBits-1:0] LastAddr = AddrBits'(Depth - 1);
    localparam logic [CntBits-1:0]  DepthCnt = CntBits'(Depth);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    logic [AddrBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntBits-1:0]  ram_cnt_q, ram_cnt_d;
    logic                rd_pending_q, rd_pending_d;
    buf_state_e          buf_state_q, buf_state_d;
    logic [Width-1:0]    buf0_q, buf0_d;
    logic [Width-1:0]    buf1_q, buf1_d;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [1:0] held;
    logic [2:0] demand;

    assign bus.in_ready    = (ram_cnt_q != DepthCnt);
    assign bus.out_valid   = (buf_state_q != BUF_EMPTY);
    assign bus.out_data    = buf0_q;
    assign bus.ram_wr_en   = push;
    assign bus.ram_wr_addr = wr_ptr_q;
    assign bus.ram_wr_data = bus.in_data;
    assign bus.ram_rd_addr = rd_ptr_q;
    assign bus.count       = ram_cnt_q + CntBits'(rd_pending_q) + CntBits'(held);

    always_comb begin
        held     = buf_state_q;
        push     = bus.in_valid && bus.in_ready;
        pop      = bus.out_valid && bus.out_ready;
        // Words the buffer must still absorb after this edge; keep it <= 2.
        demand   = {1'b0, held} + {2'b0, rd_pending_q} - {2'b0, pop};
        rd_issue = (ram_cnt_q != '0) && (demand <= 3'd1);

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_issue) begin
            rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
        end
        ram_cnt_d    = ram_cnt_q + CntBits'(push) - CntBits'(rd_issue);
        rd_pending_d = rd_issue;

        buf_state_d = buf_state_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        case (buf_state_q)
            BUF_EMPTY: begin
                if (rd_pending_q) begin
                    buf0_d      = bus.ram_rd_data;
                    buf_state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (pop && rd_pending_q) begin
                    buf0_d = bus.ram_rd_data;
                end else if (pop) begin
                    buf_state_d = BUF_EMPTY;
                end else if (rd_pending_q) begin
                    buf1_d      = bus.ram_rd_data;
                    buf_state_d = BUF_TWO;
                end
            end
            BUF_TWO: begin
                // A read is never in flight into a full buffer without a pop.
                if (pop) begin
                    buf0_d = buf1_q;
                    if (rd_pending_q) begin
                        buf1_d = bus.ram_rd_data;
                    end else begin
                        buf_state_d = BUF_ONE;
                    end
                end
            end
            default: buf_state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            buf_state_q  <= BUF_EMPTY;
            buf0_q       <= '0;
            buf1_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            rd_pending_q <= rd_pending_d;
            buf_state_q  <= buf_state_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
        end
    end

    no_rd_wr_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.ram_wr_en && rd_issue && (bus.ram_wr_addr == bus.ram_rd_addr)));
endmodule
